// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio gain stage: default widths, the unity gain
// code and the stereo sample-pair entry type.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_GAIN_W = 4;
    localparam int DEF_FRAC_W = 3;

    // Gain code that multiplies a sample by exactly 1.0
    localparam int UNITY_GAIN = 1 << DEF_FRAC_W;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] l;
        logic signed [DEF_DATA_W-1:0] r;
    } sample_pair_t;

endpackage

// File: rtl/audio_gain_stage_if.sv
// -----------------------------------------------------------------------------
// audio_gain_stage_if
// Codec-side streaming bundle of the gain stage: the input pair with its
// available/read handshake and the output pair with its allowed/write
// handshake.
//   master : codec side (offers input pairs, grants output slots)
//   slave  : gain stage side (accepts input pairs, presents output pairs)
// -----------------------------------------------------------------------------
interface audio_gain_stage_if
    import audio_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                     audio_in_available;
    logic signed [DATA_W-1:0] audio_in_L;
    logic signed [DATA_W-1:0] audio_in_R;
    logic                     read_audio_in;

    logic                     audio_out_allowed;
    logic                     write_audio_out;
    logic signed [DATA_W-1:0] audio_out_L;
    logic signed [DATA_W-1:0] audio_out_R;

    modport master (
        output audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
        input  read_audio_in, write_audio_out, audio_out_L, audio_out_R
    );

    modport slave (
        input  audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
        output read_audio_in, write_audio_out, audio_out_L, audio_out_R
    );

endinterface

// File: rtl/audio_pair_fifo.sv
// -----------------------------------------------------------------------------
// audio_pair_fifo
// Small synchronous FIFO of stereo sample pairs with first-word fall-through
// head output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset of pointers/count
//   push, push_data   write request and entry (ignored while full)
//   pop               read request (ignored while empty)
//   head              oldest entry, valid whenever !empty
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module audio_pair_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sample_pair_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_gain_stage.sv
// -----------------------------------------------------------------------------
// audio_gain_stage
// Stereo gain stage between a codec input and output stream. Input pairs are
// buffered in a small FIFO, scaled by a ramped gain code with saturation, and
// held in a single output register until the codec takes them.
// Ports:
//   CLOCK_50      sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   codec         streaming bundle (input pair/handshake, output pair/handshake)
//   gain_target   requested gain code, FRAC_W fractional bits
//   mute          ramps the gain toward 0
//   clip          sticky flag, set when any output sample saturated
//   clip_clr      clears clip (a concurrent new saturation wins)
//   fifo_count    input FIFO occupancy
// -----------------------------------------------------------------------------
module audio_gain_stage
    import audio_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAIN_W     = DEF_GAIN_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    audio_gain_stage_if.slave             codec,
    input  logic [GAIN_W-1:0]             gain_target,
    input  logic                          mute,
    output logic                          clip,
    input  logic                          clip_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic signed [DATA_W-1:0] l;
        logic signed [DATA_W-1:0] r;
    } pair_t;

    // Gain is unsigned: zero-extend it so the signed multiply treats it as positive
    function automatic logic signed [PROD_W-1:0] scale(
        input logic signed [DATA_W-1:0] s,
        input logic [GAIN_W-1:0]        g
    );
        logic signed [PROD_W-1:0] ss;
        logic signed [PROD_W-1:0] gs;
        logic signed [PROD_W-1:0] prod;
        ss   = PROD_W'(s);
        gs   = PROD_W'($signed({1'b0, g}));
        prod = ss * gs;
        return prod >>> FRAC_W;
    endfunction

    function automatic logic clamps(input logic signed [PROD_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [PROD_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    pair_t                    in_pair;
    pair_t                    head_p0;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     out_take;

    logic signed [PROD_W-1:0] scaled_l_p0;
    logic signed [PROD_W-1:0] scaled_r_p0;
    logic                     clamp_p0;

    logic [GAIN_W-1:0]        cur_gain;
    logic [GAIN_W-1:0]        ramp_target;
    logic [GAIN_W-1:0]        next_gain;

    logic                     vld_p1;
    logic signed [DATA_W-1:0] out_l_p1;
    logic signed [DATA_W-1:0] out_r_p1;

    // Handshakes are combinational; reset_n gates acceptance so nothing is
    // offered as read while the block is held in reset
    assign push                 = reset_n && codec.audio_in_available && !fifo_full;
    assign codec.read_audio_in  = push;
    assign out_take             = vld_p1 && codec.audio_out_allowed;
    assign codec.write_audio_out = out_take;
    assign pop                  = !fifo_empty && (!vld_p1 || out_take);

    assign in_pair.l = codec.audio_in_L;
    assign in_pair.r = codec.audio_in_R;

    audio_pair_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (pair_t)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (in_pair),
        .pop       (pop),
        .head      (head_p0),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---- stage p0: FIFO head scaled by the current (pre-update) gain ----
    assign scaled_l_p0 = scale(head_p0.l, cur_gain);
    assign scaled_r_p0 = scale(head_p0.r, cur_gain);
    assign clamp_p0    = clamps(scaled_l_p0) || clamps(scaled_r_p0);

    // Gain only ever moves one code per popped pair, so target or mute changes
    // bend the ramp instead of stepping the output
    always_comb begin
        ramp_target = mute ? '0 : gain_target;
        next_gain   = cur_gain;
        if (cur_gain < ramp_target) begin
            next_gain = cur_gain + GAIN_W'(1);
        end else if (cur_gain > ramp_target) begin
            next_gain = cur_gain - GAIN_W'(1);
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            out_l_p1 <= '0;
            out_r_p1 <= '0;
            cur_gain <= '0;
            clip     <= 1'b0;
        end else begin
            if (pop) begin
                vld_p1   <= 1'b1;
                out_l_p1 <= sat(scaled_l_p0);
                out_r_p1 <= sat(scaled_r_p0);
                cur_gain <= next_gain;
            end else if (out_take) begin
                vld_p1   <= 1'b0;
            end

            // A fresh saturation outranks a clear in the same cycle
            if (pop && clamp_p0) begin
                clip <= 1'b1;
            end else if (clip_clr) begin
                clip <= 1'b0;
            end
        end
    end

    assign codec.audio_out_L = out_l_p1;
    assign codec.audio_out_R = out_r_p1;

endmodule

// File: tb/tb_audio_gain_stage.sv
// -----------------------------------------------------------------------------
// tb_audio_gain_stage
// Self-checking bench for audio_gain_stage: a queue-based behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_audio_gain_stage;

    localparam int DATA_W     = 32;
    localparam int GAIN_W     = 4;
    localparam int FRAC_W     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam longint SMAX   = 64'sd2147483647;
    localparam longint SMIN   = -64'sd2147483648;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b1;
    logic [GAIN_W-1:0] gain_target = '0;
    logic              mute     = 1'b0;
    logic              clip_clr = 1'b0;
    logic              clip;
    logic [2:0]        fifo_count;

    audio_gain_stage_if #(.DATA_W(DATA_W)) codec ();

    audio_gain_stage #(
        .DATA_W     (DATA_W),
        .GAIN_W     (GAIN_W),
        .FRAC_W     (FRAC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .codec       (codec),
        .gain_target (gain_target),
        .mute        (mute),
        .clip        (clip),
        .clip_clr    (clip_clr),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint l;
        longint r;
    } mpair_t;

    // Model state: queue of buffered pairs, one output slot, gain, clip
    mpair_t mq[$];
    logic   m_vld  = 1'b0;
    longint m_l    = 0;
    longint m_r    = 0;
    int     m_gain = 0;
    logic   m_clip = 1'b0;

    longint log_l[$];
    longint log_r[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // sample * gain / 2^FRAC_W rounded toward minus infinity
    function automatic longint scale_floor(input longint s, input int g);
        longint p;
        longint q;
        p = s * g;
        q = p / (64'sd1 << FRAC_W);
        if (p < 0 && q * (64'sd1 << FRAC_W) != p) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    always @(negedge clk) begin
        logic   e_read;
        logic   e_write;
        logic   do_pop;
        logic   hit;
        longint vl;
        longint vr;
        int     tgt;
        mpair_t p;

        if (!reset_n) begin
            mq.delete();
            m_vld  = 1'b0;
            m_l    = 0;
            m_r    = 0;
            m_gain = 0;
            m_clip = 1'b0;
        end

        e_read  = reset_n && codec.audio_in_available && (mq.size() < FIFO_DEPTH);
        e_write = m_vld && codec.audio_out_allowed;

        chk("read_audio_in", longint'(codec.read_audio_in), longint'(e_read));
        chk("write_audio_out", longint'(codec.write_audio_out), longint'(e_write));
        chk("audio_out_L", longint'(codec.audio_out_L), m_l);
        chk("audio_out_R", longint'(codec.audio_out_R), m_r);
        chk("fifo_count", longint'(fifo_count), longint'(mq.size()));
        chk("clip", longint'(clip), longint'(m_clip));

        if (codec.write_audio_out) begin
            log_l.push_back(longint'(codec.audio_out_L));
            log_r.push_back(longint'(codec.audio_out_R));
        end

        if (reset_n) begin
            do_pop = (mq.size() > 0) && (!m_vld || e_write);
            hit    = 1'b0;
            if (do_pop) begin
                p     = mq.pop_front();
                vl    = scale_floor(p.l, m_gain);
                vr    = scale_floor(p.r, m_gain);
                hit   = (clamp(vl) != vl) || (clamp(vr) != vr);
                m_l   = clamp(vl);
                m_r   = clamp(vr);
                m_vld = 1'b1;
                tgt   = mute ? 0 : int'(gain_target);
                if (m_gain < tgt) m_gain = m_gain + 1;
                else if (m_gain > tgt) m_gain = m_gain - 1;
            end else if (e_write) begin
                m_vld = 1'b0;
            end
            if (hit) m_clip = 1'b1;
            else if (clip_clr) m_clip = 1'b0;
            if (e_read) begin
                p.l = longint'(codec.audio_in_L);
                p.r = longint'(codec.audio_in_R);
                mq.push_back(p);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_l.delete();
        log_r.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input longint el, input longint er);
        if (idx < log_l.size()) begin
            chk($sformatf("%s[%0d].L", name, idx), log_l[idx], el);
            chk($sformatf("%s[%0d].R", name, idx), log_r[idx], er);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: entry missing, log holds %0d", name, idx, log_l.size());
        end
    endtask

    longint ramp_up[10]   = '{0, 125, 250, 375, 500, 625, 750, 875, 1000, 1000};
    longint mute_down[11] = '{1000, 1000, 875, 750, 625, 500, 375, 250, 125, 0, 0};
    longint unmute_up[10] = '{0, 0, 125, 250, 375, 500, 625, 750, 875, 1000};

    initial begin
        int acc;

        // Reset with the codec already offering data
        reset_n                  = 1'b0;
        codec.audio_in_available = 1'b1;
        codec.audio_out_allowed  = 1'b1;
        codec.audio_in_L         = 32'sd1000;
        codec.audio_in_R         = -32'sd1000;
        gain_target              = 4'd8;
        cyc(3);
        chk("rst_read", longint'(codec.read_audio_in), 0);
        chk("rst_write", longint'(codec.write_audio_out), 0);
        chk("rst_fifo_count", longint'(fifo_count), 0);
        chk("rst_out_L", longint'(codec.audio_out_L), 0);
        chk("rst_clip", longint'(clip), 0);

        // Ramp up from gain 0 to unity
        reset_n = 1'b1;
        clear_log();
        cyc(25);
        for (int i = 0; i < 10; i++) chk_log("ramp", i, ramp_up[i], -ramp_up[i]);

        // Mute ramps down to 0, unmute ramps back to unity
        clear_log();
        mute = 1'b1;
        cyc(14);
        for (int i = 0; i < 11; i++) chk_log("mute", i, mute_down[i], -mute_down[i]);
        clear_log();
        mute = 1'b0;
        cyc(14);
        for (int i = 0; i < 10; i++) chk_log("unmute", i, unmute_up[i], -unmute_up[i]);

        // Saturation at full-scale input with gain ramping to 15
        gain_target      = 4'd15;
        codec.audio_in_L = 32'sh7FFFFFFF;
        codec.audio_in_R = 32'sh80000000;
        clear_log();
        cyc(20);
        chk("sat_L", log_l[log_l.size()-1], SMAX);
        chk("sat_R", log_r[log_r.size()-1], SMIN);
        chk("sat_clip", longint'(clip), 1);
        clip_clr = 1'b1;
        cyc(2);
        chk("clip_set_wins", longint'(clip), 1);
        clip_clr = 1'b0;
        codec.audio_in_available = 1'b0;
        cyc(5);
        clip_clr = 1'b1;
        cyc(1);
        clip_clr = 1'b0;
        chk("clip_cleared", longint'(clip), 0);

        // Empty pipeline with the output side open
        chk("empty_write", longint'(codec.write_audio_out), 0);
        chk("empty_count", longint'(fifo_count), 0);

        // Backpressure: 4 FIFO entries + 1 output register
        codec.audio_out_allowed  = 1'b0;
        codec.audio_in_available = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            codec.audio_in_L = 32'(8 * (i + 1));
            codec.audio_in_R = 32'(-8 * (i + 1));
            #1;
            if (codec.read_audio_in) acc++;
            cyc(1);
        end
        chk("bp_accepted", longint'(acc), 5);
        chk("bp_fifo_count", longint'(fifo_count), 4);
        chk("bp_read_blocked", longint'(codec.read_audio_in), 0);
        codec.audio_in_available = 1'b0;
        codec.audio_out_allowed  = 1'b1;
        clear_log();
        cyc(8);
        chk("bp_drained", longint'(log_l.size()), 5);
        for (int i = 0; i < 5; i++) chk_log("bp", i, 15 * (i + 1), -15 * (i + 1));

        // Reset with pairs buffered and one pending in the output register
        codec.audio_out_allowed  = 1'b0;
        codec.audio_in_available = 1'b1;
        codec.audio_in_L         = 32'sd1000;
        codec.audio_in_R         = -32'sd1000;
        cyc(4);
        chk("mid_fifo_count", longint'(fifo_count), 3);
        reset_n                  = 1'b0;
        codec.audio_in_available = 1'b0;
        codec.audio_out_allowed  = 1'b1;
        #1;
        chk("mid_rst_count", longint'(fifo_count), 0);
        chk("mid_rst_write", longint'(codec.write_audio_out), 0);
        chk("mid_rst_L", longint'(codec.audio_out_L), 0);
        chk("mid_rst_R", longint'(codec.audio_out_R), 0);
        cyc(2);
        reset_n = 1'b1;
        clear_log();
        codec.audio_in_available = 1'b1;
        cyc(1);
        codec.audio_in_available = 1'b0;
        cyc(6);
        chk("post_rst_pairs", longint'(log_l.size()), 1);
        chk_log("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
